// File: rtl/uart_rx_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
package uart_rx_pkg;

    // 50 MHz system clock, 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // Baud count at which the start bit is re-checked (middle of the bit)
    function automatic logic [15:0] uart_half_bit(input int unsigned cpb);
        return 16'((cpb - 1) / 2);
    endfunction

    // Baud count at which data and stop bits are sampled
    function automatic logic [15:0] uart_last_cnt(input int unsigned cpb);
        return 16'(cpb - 1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: byte, handshake and status flags.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       framing_err;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, rx_busy, framing_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, framing_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value; also used on the CPU reset path.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops resolve metastability on the asynchronous input
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, one-byte holding register.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        rx,
    uart_rx_if.master   bus
);

    localparam logic [15:0] HALF_CNT = uart_half_bit(CLKS_PER_BIT);
    localparam logic [15:0] LAST_CNT = uart_last_cnt(CLKS_PER_BIT);

    uart_state_e state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        fe_q;
    logic        ovr_q;
    logic        rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Receive FSM, holding register and status flags, all registered
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
            // Consumption; a byte completing this cycle overrides it below
            if (valid_q && bus.rx_ready)
                valid_q <= 1'b0;

            if (state != ST_IDLE && !ena) begin
                // Disable aborts the frame silently; the holding register is kept
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s && ena) begin
                            state    <= ST_START;
                            busy_q   <= 1'b1;
                            baud_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (baud_cnt == HALF_CNT) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            if (!rx_s) begin
                                state <= ST_DATA;
                            end else begin
                                // Line went high again: a glitch, not a start bit
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (baud_cnt == LAST_CNT) begin
                            baud_cnt       <= '0;
                            shreg[bit_idx] <= rx_s;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                state <= ST_STOP;
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (baud_cnt == LAST_CNT) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            if (rx_s) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                if (!valid_q || bus.rx_ready) begin
                                    data_q  <= shreg;
                                    valid_q <= 1'b1;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end else begin
                                fe_q  <= 1'b1;
                                state <= ST_WAIT_HIGH;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        // Ride out a break until the line returns to idle
                        if (rx_s) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.rx_busy     = busy_q;
    assign bus.framing_err = fe_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=16 and a byte scoreboard.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CPB = 16;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .ena   (ena),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         nvec    = 0;
    int         nfail   = 0;
    logic [7:0] exp_q[$];
    int         fe_cyc  = 0;
    int         ovr_cyc = 0;
    int         exp_fe  = 0;
    int         exp_ovr = 0;
    logic       prev_valid = 1'b0;
    logic       prev_cons  = 1'b0;
    logic [7:0] d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard whenever a fresh byte is presented, count flag cycles
    always @(negedge clock) begin : monitor
        logic [7:0] e;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_cons  = 1'b0;
        end else begin
            if (bus.rx_valid && (!prev_valid || prev_cons)) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data_sb", {24'd0, bus.rx_data}, {24'd0, e});
                end
            end
            if (bus.framing_err === 1'b1) fe_cyc++;
            if (bus.overrun === 1'b1) ovr_cyc++;
            prev_valid = bus.rx_valid;
            prev_cons  = bus.rx_valid && bus.rx_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(stop);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.rx_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data", 32'(bus.rx_data), 32'd0);
        check("rst_busy", 32'(bus.rx_busy), 32'd0);
        check("rst_fe", 32'(bus.framing_err), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(5);

        // Single frame 0xA5, consumer not ready; valid appears after stop-bit sample
        d = 8'hA5;
        exp_q.push_back(8'hA5);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rx = 1'b1;
        tick(10);
        check("a5_valid_pre", 32'(bus.rx_valid), 32'd0);
        tick(1);
        check("a5_valid_post", 32'(bus.rx_valid), 32'd1);
        check("a5_data", 32'(bus.rx_data), 32'hA5);
        tick(25);
        check("a5_valid_held", 32'(bus.rx_valid), 32'd1);
        check("a5_data_held", 32'(bus.rx_data), 32'hA5);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check("a5_valid_cleared", 32'(bus.rx_valid), 32'd0);
        check("a5_data_kept", 32'(bus.rx_data), 32'hA5);

        // Short low glitch rejected at the start-bit re-check
        rx = 1'b0;
        tick(4);
        check("glitch_busy", 32'(bus.rx_busy), 32'd1);
        rx = 1'b1;
        tick(20);
        check("glitch_idle", 32'(bus.rx_busy), 32'd0);
        check("glitch_valid", 32'(bus.rx_valid), 32'd0);
        check("glitch_fe", 32'(fe_cyc), 32'(exp_fe));
        check("glitch_ovr", 32'(ovr_cyc), 32'(exp_ovr));

        // Frame 0x3C with a low stop bit and a long break
        d = 8'h3C;
        exp_fe++;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rx = 1'b0;
        tick(40);
        check("fe_pulses", 32'(fe_cyc), 32'(exp_fe));
        check("fe_valid", 32'(bus.rx_valid), 32'd0);
        check("fe_wait_high", 32'(bus.rx_busy), 32'd1);
        rx = 1'b1;
        tick(4);
        check("fe_idle", 32'(bus.rx_busy), 32'd0);

        // Back-to-back 0x11, 0x22 without consumption: second byte dropped
        exp_q.push_back(8'h11);
        exp_ovr++;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        check("ovr_data", 32'(bus.rx_data), 32'h11);
        check("ovr_valid", 32'(bus.rx_valid), 32'd1);
        check("ovr_pulses", 32'(ovr_cyc), 32'(exp_ovr));
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check("ovr_consumed", 32'(bus.rx_valid), 32'd0);

        // Back-to-back 0x55, 0xAA with consumer always ready
        bus.rx_ready = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        tick(4);
        check("b2b_data", 32'(bus.rx_data), 32'hAA);
        check("b2b_valid", 32'(bus.rx_valid), 32'd0);
        check("b2b_fe", 32'(fe_cyc), 32'(exp_fe));
        check("b2b_ovr", 32'(ovr_cyc), 32'(exp_ovr));
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        bus.rx_ready = 1'b0;

        // Disable mid-frame aborts without producing a byte
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("ena_busy", 32'(bus.rx_busy), 32'd1);
        ena = 1'b0;
        tick(1);
        check("ena_abort", 32'(bus.rx_busy), 32'd0);
        rx = 1'b1;
        tick(CPB * 8);
        ena = 1'b1;
        tick(5);
        check("ena_idle", 32'(bus.rx_busy), 32'd0);
        check("ena_valid", 32'(bus.rx_valid), 32'd0);
        check("ena_data", 32'(bus.rx_data), 32'hAA);

        // Reset during data bit 3 of 0xFF, then a clean 0x01 frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b1;
        tick(8);
        check("rst_mid_busy", 32'(bus.rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_mid_data", 32'(bus.rx_data), 32'd0);
        check("rst_mid_busy0", 32'(bus.rx_busy), 32'd0);
        check("rst_mid_fe", 32'(bus.framing_err), 32'd0);
        check("rst_mid_ovr", 32'(bus.overrun), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(CPB * 6);
        check("rst_rel_idle", 32'(bus.rx_busy), 32'd0);
        check("rst_rel_valid", 32'(bus.rx_valid), 32'd0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        tick(4);
        check("post_rst_data", 32'(bus.rx_data), 32'h01);
        check("post_rst_valid", 32'(bus.rx_valid), 32'd1);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        check("final_fe", 32'(fe_cyc), 32'(exp_fe));
        check("final_ovr", 32'(ovr_cyc), 32'(exp_ovr));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
